async_reset_reg_vec: RTL

Parametrised multi-stage, multi-bit async-reset register pipeline: the general-purpose replacement for the single-bit async-reset flop used across the clock-crossing and reset-domain logic. Carries a `WIDTH`-bit word through `DEPTH` async-reset stages with a per-bit reset value and a clock enable. An internal reset-release synchronizer and settle counter raise `q_valid` only once the pipeline has been refilled after reset. It sits at reset-domain and clock-domain boundaries, feeding status/control bits into logic that must not act on stale reset values.

---
 rtl/async_reset_reg_pkg.sv | 12 +
 rtl/async_reset_sync.sv | 25 ++
 rtl/async_reset_reg_vec.sv | 76 +++++++
 3 files changed

// File: rtl/async_reset_reg_pkg.sv
// Shared constants and helpers for the async-reset register pipeline family.
package async_reset_reg_pkg;

  localparam int DEPTH_DEFAULT    = 2;
  localparam int RST_SYNC_DEFAULT = 2;

  // Settle counter must hold the value DEPTH itself.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/async_reset_sync.sv
// Reset-release synchronizer: rst asserts rst_i at once, release is delayed
// by RST_SYNC rising clk edges so downstream logic leaves reset cleanly.
module async_reset_sync
  import async_reset_reg_pkg::*;
#(
  parameter int RST_SYNC = RST_SYNC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic rst_i
);

  logic [RST_SYNC-1:0] sync_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p <= '1;
    end else begin
      sync_p <= {sync_p[RST_SYNC-2:0], 1'b0};
    end
  end

  assign rst_i = sync_p[RST_SYNC-1];

endmodule

// File: rtl/async_reset_reg_vec.sv
// Multi-stage, multi-bit async-reset register pipeline with settle tracking.
// Define ASYNC_RESET_REG_VEC_CHANGE_EN to build the q_prev change detector.
module async_reset_reg_vec
  import async_reset_reg_pkg::*;
#(
  parameter int               WIDTH    = 1,
  parameter int               DEPTH    = DEPTH_DEFAULT,
  parameter logic [WIDTH-1:0] INIT     = '0,
  parameter int               RST_SYNC = RST_SYNC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             changed
);

  localparam int             CW      = cnt_width(DEPTH);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH);

  logic             rst_i;
  logic [WIDTH-1:0] stage_p [DEPTH];
  logic [CW-1:0]    cnt;

  async_reset_sync #(
    .RST_SYNC (RST_SYNC)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .rst_i (rst_i)
  );

  // Stage array: data runs as soon as rst drops, independent of rst_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_p[i] <= INIT;
    end else if (en) begin
      stage_p[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
    end
  end

  assign q = stage_p[DEPTH-1];

  // Settle counter: counts enabled edges after the synchronized release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rst_i) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign q_valid = (cnt == CNT_MAX);

`ifdef ASYNC_RESET_REG_VEC_CHANGE_EN
  logic [WIDTH-1:0] q_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_prev <= INIT;
    end else if (en) begin
      q_prev <= q;
    end
  end

  assign changed = q_valid & (q != q_prev);
`else
  assign changed = 1'b0;
`endif

endmodule
